neighbourhood_fetcher: RTL

- Sequential 3x3 neighbourhood fetcher for image-processing kernels (Sobel, blur) working on a frame buffer held in single-port synchronous BRAM.
- Accepts one centre coordinate per request and issues the 9 tap reads to the frame buffer, one per cycle.
- Collects the returned pixels and presents the full window on a valid/ready output.
- Frame size, pixel width, BRAM read latency and border policy are parameters; the neighbouring kernel block consumes the window.

---
 rtl/neighbourhood_pkg.sv | 37 +++
 rtl/tap_address_calc.sv | 70 +++++++
 rtl/neighbourhood_fetcher.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/neighbourhood_pkg.sv
// Shared types and constants for the 3x3 neighbourhood fetcher.
//   border_mode_e : policy applied to taps that fall outside the frame
//   state_e       : fetcher FSM states
//   TAP_DX/TAP_DY : row-major tap offsets, tap 4 is the centre
package neighbourhood_pkg;

   typedef enum logic {
      BORDER_ZERO      = 1'b0,
      BORDER_REPLICATE = 1'b1
   } border_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned TAPS     = 9;
   localparam int unsigned TAP_W    = 4;
   localparam int unsigned COORD_W  = 11;
   // One extra bit so that x-1 at x=0 stays negative instead of wrapping
   localparam int unsigned SCOORD_W = 12;

   localparam logic signed [1:0] TAP_DX [TAPS] = '{
      -2'sd1, 2'sd0, 2'sd1,
      -2'sd1, 2'sd0, 2'sd1,
      -2'sd1, 2'sd0, 2'sd1
   };

   localparam logic signed [1:0] TAP_DY [TAPS] = '{
      -2'sd1, -2'sd1, -2'sd1,
       2'sd0,  2'sd0,  2'sd0,
       2'sd1,  2'sd1,  2'sd1
   };

endpackage

// File: rtl/tap_address_calc.sv
// Combinational tap address generator.
//   cx, cy : centre coordinate
//   tap    : tap index 0..8 (row-major)
//   addr   : frame-buffer address of the clamped tap coordinate
//   oof    : tap coordinate lies outside the frame
module tap_address_calc
   import neighbourhood_pkg::*;
#(
   parameter int unsigned IMG_W  = 512,
   parameter int unsigned IMG_H  = 384,
   parameter int unsigned ADDR_W = 18
)(
   input  logic [COORD_W-1:0] cx,
   input  logic [COORD_W-1:0] cy,
   input  logic [TAP_W-1:0]   tap,
   output logic [ADDR_W-1:0]  addr,
   output logic               oof
);

   localparam logic signed [SCOORD_W-1:0] X_MAX = SCOORD_W'(IMG_W - 1);
   localparam logic signed [SCOORD_W-1:0] Y_MAX = SCOORD_W'(IMG_H - 1);

   logic signed [1:0]          dx;
   logic signed [1:0]          dy;
   logic signed [SCOORD_W-1:0] tx;
   logic signed [SCOORD_W-1:0] ty;
   logic [COORD_W-1:0]         clx;
   logic [COORD_W-1:0]         cly;
   logic                       ox;
   logic                       oy;

   // Offset, clamp and flag the tap coordinate
   always_comb begin
      dx = 2'sd0;
      dy = 2'sd0;
      if (32'(tap) < TAPS) begin
         dx = TAP_DX[tap];
         dy = TAP_DY[tap];
      end

      tx = $signed({1'b0, cx}) + $signed({{(SCOORD_W-2){dx[1]}}, dx});
      ty = $signed({1'b0, cy}) + $signed({{(SCOORD_W-2){dy[1]}}, dy});

      ox = 1'b0;
      if (tx[SCOORD_W-1]) begin
         clx = '0;
         ox  = 1'b1;
      end else if (tx > X_MAX) begin
         clx = X_MAX[COORD_W-1:0];
         ox  = 1'b1;
      end else begin
         clx = tx[COORD_W-1:0];
      end

      oy = 1'b0;
      if (ty[SCOORD_W-1]) begin
         cly = '0;
         oy  = 1'b1;
      end else if (ty > Y_MAX) begin
         cly = Y_MAX[COORD_W-1:0];
         oy  = 1'b1;
      end else begin
         cly = ty[COORD_W-1:0];
      end

      addr = ADDR_W'(cly) * ADDR_W'(IMG_W) + ADDR_W'(clx);
      oof  = ox | oy;
   end

endmodule

// File: rtl/neighbourhood_fetcher.sv
// Sequential 3x3 neighbourhood fetcher: one centre coordinate in, nine
// BRAM reads out (one per cycle), full window presented on valid/ready.
//   clk, rst              : clock, async active-high reset
//   req_valid/ready/x/y   : centre coordinate request
//   mem_en/addr/rdata     : single-port synchronous BRAM read port
//   win_valid/ready/data  : assembled window, tap k at [k*DATA_W +: DATA_W]
//   win_err               : request coordinate was outside the frame
module neighbourhood_fetcher
   import neighbourhood_pkg::*;
#(
   parameter int unsigned  IMG_W       = 512,
   parameter int unsigned  IMG_H       = 384,
   parameter int unsigned  DATA_W      = 12,
   parameter int unsigned  RD_LATENCY  = 2,
   parameter border_mode_e BORDER_MODE = BORDER_ZERO,
   localparam int unsigned ADDR_W      = $clog2(IMG_W * IMG_H)
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [COORD_W-1:0]     req_x,
   input  logic [COORD_W-1:0]     req_y,
   output logic                   mem_en,
   output logic [ADDR_W-1:0]      mem_addr,
   input  logic [DATA_W-1:0]      mem_rdata,
   output logic                   win_valid,
   input  logic                   win_ready,
   output logic [TAPS*DATA_W-1:0] win_data,
   output logic                   win_err
);

   localparam int unsigned      CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LATENCY - 1);

   state_e             state_q;
   state_e             state_d;
   logic [COORD_W-1:0] cx_q;
   logic [COORD_W-1:0] cx_d;
   logic [COORD_W-1:0] cy_q;
   logic [COORD_W-1:0] cy_d;
   logic [TAP_W-1:0]   tap_q;
   logic [TAP_W-1:0]   tap_d;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;
   logic               flag_q;
   logic               flag_d;
   logic               req_ready_d;
   logic               mem_en_d;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic               win_valid_d;
   logic               win_err_d;
   logic               clear_win;
   logic               coord_ok;

   logic [COORD_W-1:0] calc_x;
   logic [COORD_W-1:0] calc_y;
   logic [TAP_W-1:0]   calc_tap;
   logic [ADDR_W-1:0]  calc_addr;
   logic               calc_oof;

   // Read tags: which slot the returning data belongs to and its border flag
   logic               pipe_vld  [RD_LATENCY];
   logic [TAP_W-1:0]   pipe_idx  [RD_LATENCY];
   logic               pipe_flag [RD_LATENCY];
   logic               zero_slot;

   assign coord_ok = (32'(req_x) < IMG_W) && (32'(req_y) < IMG_H);

   // Address of the tap presented on mem_addr in the following cycle
   always_comb begin
      if (state_q == IDLE) begin
         calc_x   = req_x;
         calc_y   = req_y;
         calc_tap = '0;
      end else begin
         calc_x   = cx_q;
         calc_y   = cy_q;
         calc_tap = (tap_q == LAST_TAP) ? '0 : tap_q + TAP_W'(1);
      end
   end

   tap_address_calc #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .ADDR_W (ADDR_W)
   ) u_tap_address_calc (
      .cx   (calc_x),
      .cy   (calc_y),
      .tap  (calc_tap),
      .addr (calc_addr),
      .oof  (calc_oof)
   );

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      cx_d        = cx_q;
      cy_d        = cy_q;
      tap_d       = tap_q;
      cnt_d       = cnt_q;
      flag_d      = flag_q;
      mem_en_d    = 1'b0;
      mem_addr_d  = mem_addr;
      win_valid_d = win_valid;
      win_err_d   = win_err;
      clear_win   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               cx_d      = req_x;
               cy_d      = req_y;
               clear_win = 1'b1;
               if (coord_ok) begin
                  state_d    = ISSUE;
                  mem_en_d   = 1'b1;
                  mem_addr_d = calc_addr;
                  flag_d     = calc_oof;
                  tap_d      = '0;
               end else begin
                  state_d     = DONE;
                  win_valid_d = 1'b1;
                  win_err_d   = 1'b1;
               end
            end
         end
         ISSUE: begin
            if (tap_q == LAST_TAP) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end else begin
               mem_en_d   = 1'b1;
               mem_addr_d = calc_addr;
               flag_d     = calc_oof;
               tap_d      = tap_q + TAP_W'(1);
            end
         end
         DRAIN: begin
            if (cnt_q == LAST_CNT) begin
               state_d     = DONE;
               win_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (win_ready) begin
               state_d     = IDLE;
               win_valid_d = 1'b0;
               win_err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase

      req_ready_d = (state_d == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cx_q      <= '0;
         cy_q      <= '0;
         tap_q     <= '0;
         cnt_q     <= '0;
         flag_q    <= 1'b0;
         req_ready <= 1'b1;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         win_valid <= 1'b0;
         win_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         tap_q     <= tap_d;
         cnt_q     <= cnt_d;
         flag_q    <= flag_d;
         req_ready <= req_ready_d;
         mem_en    <= mem_en_d;
         mem_addr  <= mem_addr_d;
         win_valid <= win_valid_d;
         win_err   <= win_err_d;
      end
   end

   // Tag delay line, aligned with the BRAM read latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_vld[i]  <= 1'b0;
            pipe_idx[i]  <= '0;
            pipe_flag[i] <= 1'b0;
         end
      end else begin
         pipe_vld[0]  <= mem_en;
         pipe_idx[0]  <= tap_q;
         pipe_flag[0] <= flag_q;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_idx[i]  <= pipe_idx[i-1];
            pipe_flag[i] <= pipe_flag[i-1];
         end
      end
   end

   assign zero_slot = (BORDER_MODE == BORDER_ZERO) && pipe_flag[RD_LATENCY-1];

   // Window register: slots fill as read data returns, held while in DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_data <= '0;
      end else if (clear_win) begin
         win_data <= '0;
      end else if (pipe_vld[RD_LATENCY-1]) begin
         for (int k = 0; k < TAPS; k++) begin
            if (pipe_idx[RD_LATENCY-1] == TAP_W'(k)) begin
               win_data[k*DATA_W +: DATA_W] <= zero_slot ? '0 : mem_rdata;
            end
         end
      end
   end

endmodule
